// File: rtl/tour_move_sequencer.sv
// Knight-tour move sequencer: launches the solver, reads back each move and issues it
// downstream over valid/ready. Optional solver watchdog enabled by `define TOUR_TIMEOUT_EN.
module tour_move_sequencer #(
  parameter int unsigned NUM_MOVES   = 24
`ifdef TOUR_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1 << 20
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic [2:0] x_start,
  input  logic [2:0] y_start,
  input  logic       abort,
  output logic       slv_go,
  output logic [2:0] slv_x,
  output logic [2:0] slv_y,
  input  logic       slv_done,
  output logic [4:0] slv_indx,
  input  logic [7:0] slv_move,
  output logic       mv_vld,
  output logic [7:0] mv_move,
  output logic [4:0] mv_idx,
  input  logic       mv_rdy,
  output logic       busy,
  output logic       tour_done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned MV_W  = 8;
  localparam int unsigned CRD_W = 3;
  localparam int unsigned EC_W  = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(4);

  localparam logic [EC_W-1:0] EC_NONE  = 2'b00;
  localparam logic [EC_W-1:0] EC_START = 2'b01;
  localparam logic [EC_W-1:0] EC_TMO   = 2'b10;
  localparam logic [EC_W-1:0] EC_MOVE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_SOLVE, S_FETCH, S_CAPT, S_ISSUE, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               slv_go_q, slv_go_d;
  logic [CRD_W-1:0]   slv_x_q, slv_x_d;
  logic [CRD_W-1:0]   slv_y_q, slv_y_d;
  logic [IDX_W-1:0]   slv_indx_q, slv_indx_d;
  logic               mv_vld_q, mv_vld_d;
  logic [MV_W-1:0]    mv_move_q, mv_move_d;
  logic [IDX_W-1:0]   mv_idx_q, mv_idx_d;
  logic               busy_q, busy_d;
  logic               tour_done_q, tour_done_d;
  logic               err_q, err_d;
  logic [EC_W-1:0]    err_code_q, err_code_d;

  logic start_bad_c;
  logic move_ok_c;
  logic tmo_hit_c;

  assign start_bad_c = (x_start > CRD_MAX) || (y_start > CRD_MAX);
  assign move_ok_c   = $onehot(slv_move);

`ifdef TOUR_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0] tmo_q;

  // Counts SOLVE cycles; held at zero in every other state so it restarts on entry
  always_ff @(posedge clk) begin
    if (!rst_n)                tmo_q <= '0;
    else if (state_q != S_SOLVE) tmo_q <= '0;
    else                       tmo_q <= tmo_q + TMO_W'(1);
  end

  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state; abort outranks every other event outside IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start_req && !abort) state_d = start_bad_c ? S_ERR : S_LAUNCH;
        S_LAUNCH: begin
          state_d = S_SOLVE;
          idx_d   = '0;
        end
        S_SOLVE: begin
          if (slv_done)       state_d = S_FETCH;
          else if (tmo_hit_c) state_d = S_ERR;
        end
        S_FETCH:  state_d = S_CAPT;
        S_CAPT:   state_d = move_ok_c ? S_ISSUE : S_ERR;
        S_ISSUE: begin
          if (mv_rdy) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        S_DONE:   state_d = S_IDLE;
        S_ERR:    state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output next values; strobes track the state being entered so they align with it
  always_comb begin
    slv_go_d    = (state_q == S_LAUNCH) && !abort;
    slv_x_d     = slv_x_q;
    slv_y_d     = slv_y_q;
    slv_indx_d  = slv_indx_q;
    mv_move_d   = mv_move_q;
    mv_idx_d    = mv_idx_q;
    err_code_d  = err_code_q;
    mv_vld_d    = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE);
    tour_done_d = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);

    if (state_q == S_IDLE && state_d == S_LAUNCH) begin
      slv_x_d    = x_start;
      slv_y_d    = y_start;
      err_code_d = EC_NONE;
    end

    if (state_d == S_ERR) begin
      unique case (state_q)
        S_IDLE:  err_code_d = EC_START;
        S_SOLVE: err_code_d = EC_TMO;
        default: err_code_d = EC_MOVE;
      endcase
    end

    // Present the index one cycle ahead of CAPT so slv_move has settled by capture
    if (state_d == S_FETCH) slv_indx_d = idx_d;

    if (state_q == S_CAPT && !abort) begin
      mv_move_d = slv_move;
      mv_idx_d  = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slv_go_q    <= 1'b0;
      slv_x_q     <= '0;
      slv_y_q     <= '0;
      slv_indx_q  <= '0;
      mv_vld_q    <= 1'b0;
      mv_move_q   <= '0;
      mv_idx_q    <= '0;
      busy_q      <= 1'b0;
      tour_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      slv_go_q    <= slv_go_d;
      slv_x_q     <= slv_x_d;
      slv_y_q     <= slv_y_d;
      slv_indx_q  <= slv_indx_d;
      mv_vld_q    <= mv_vld_d;
      mv_move_q   <= mv_move_d;
      mv_idx_q    <= mv_idx_d;
      busy_q      <= busy_d;
      tour_done_q <= tour_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign slv_go    = slv_go_q;
  assign slv_x     = slv_x_q;
  assign slv_y     = slv_y_q;
  assign slv_indx  = slv_indx_q;
  assign mv_vld    = mv_vld_q;
  assign mv_move   = mv_move_q;
  assign mv_idx    = mv_idx_q;
  assign busy      = busy_q;
  assign tour_done = tour_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Bench for tour_move_sequencer: start-square table plus multi-cycle tour scenarios,
// with a move scoreboard checked at every downstream handshake.
module tb_tour_move_sequencer;

  localparam int unsigned NM = 24;
`ifdef TOUR_TIMEOUT_EN
  localparam int SOLVE_DLY = 40;
`else
  localparam int SOLVE_DLY = 100;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_req = 1'b0;
  logic [2:0] x_start = '0;
  logic [2:0] y_start = '0;
  logic       abort = 1'b0;
  logic       slv_go;
  logic [2:0] slv_x, slv_y;
  logic       slv_done;
  logic [4:0] slv_indx;
  logic [7:0] slv_move;
  logic       mv_vld;
  logic [7:0] mv_move;
  logic [4:0] mv_idx;
  logic       mv_rdy = 1'b1;
  logic       busy, tour_done, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  tour_move_sequencer #(
    .NUM_MOVES(NM)
`ifdef TOUR_TIMEOUT_EN
    , .TIMEOUT_CYC(64)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req), .x_start(x_start), .y_start(y_start),
    .abort(abort), .slv_go(slv_go), .slv_x(slv_x), .slv_y(slv_y), .slv_done(slv_done),
    .slv_indx(slv_indx), .slv_move(slv_move), .mv_vld(mv_vld), .mv_move(mv_move),
    .mv_idx(mv_idx), .mv_rdy(mv_rdy), .busy(busy), .tour_done(tour_done), .err(err),
    .err_code(err_code)
  );

  // Solver model: registered move lookup, done pulse a fixed delay after slv_go
  logic [7:0] mem [NM];
  int         solve_dly = SOLVE_DLY;
  int         slv_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      slv_cnt  <= 0;
      slv_done <= 1'b0;
      slv_move <= '0;
    end else begin
      slv_move <= (int'(slv_indx) < NM) ? mem[slv_indx] : 8'h00;
      if (slv_go && solve_dly >= 0) slv_cnt <= solve_dly;
      else if (slv_cnt > 0)         slv_cnt <= slv_cnt - 1;
      slv_done <= (slv_cnt == 1);
    end
  end

  typedef struct { logic [4:0] idx; logic [7:0] mv; } exp_t;
  typedef struct { logic [2:0] x; logic [2:0] y; logic bad; logic [1:0] code; } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_vec = 0, n_miss = 0;
  int   cyc = 0, go_cnt = 0, done_cnt = 0, err_cnt = 0, hs_cnt = 0;
  int   hs_at[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: observe handshakes/strobes at negedge, return just after the next posedge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (slv_go)    go_cnt++;
      if (tour_done) done_cnt++;
      if (err)       err_cnt++;
      if (mv_vld && mv_rdy) begin
        hs_cnt++;
        hs_at[mv_idx] = cyc;
        if (sb.size() == 0) begin
          chk("sb_unexpected_handshake", 32'(mv_idx), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_mv_idx", 32'(mv_idx), 32'(e.idx));
          chk("sb_mv_move", 32'(mv_move), 32'(e.mv));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_moves(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx = 5'(i);
      e.mv  = mem[i];
      sb.push_back(e);
    end
  endtask

  task automatic start(input logic [2:0] x, input logic [2:0] y);
    x_start   = x;
    y_start   = y;
    start_req = 1'b1;
    cycle();
    start_req = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, slv_go, slv_x, slv_y, slv_indx, mv_vld, mv_move, mv_idx,
                tour_done, err, err_code});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, e0, h0, n;
    for (int i = 0; i < NM; i++) mem[i] = 8'(1 << (i % 8));

    vt[0] = '{3'd0, 3'd0, 1'b0, 2'b00};
    vt[1] = '{3'd4, 3'd4, 1'b0, 2'b00};
    vt[2] = '{3'd5, 3'd1, 1'b1, 2'b01};
    vt[3] = '{3'd4, 3'd0, 1'b0, 2'b00};
    vt[4] = '{3'd0, 3'd5, 1'b1, 2'b01};
    vt[5] = '{3'd7, 3'd7, 1'b1, 2'b01};
    vt[6] = '{3'd3, 3'd2, 1'b0, 2'b00};
    vt[7] = '{3'd4, 3'd5, 1'b1, 2'b01};

    repeat (3) cycle();
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    cycle();

    // Start-square table: range check, latch, launch latency, error pulse
    foreach (vt[i]) begin
      g0 = go_cnt; e0 = err_cnt;
      start(vt[i].x, vt[i].y);
      chk("tbl_busy", 32'(busy), 1);
      chk("tbl_err", 32'(err), 32'(vt[i].bad));
      chk("tbl_err_code", 32'(err_code), 32'(vt[i].code));
      chk("tbl_go_early", 32'(slv_go), 0);
      if (!vt[i].bad) chk("tbl_slv_xy", 32'({slv_x, slv_y}), 32'({vt[i].x, vt[i].y}));
      cycle();
      chk("tbl_go_latency", 32'(slv_go), 32'(!vt[i].bad));
      chk("tbl_busy2", 32'(busy), 32'(!vt[i].bad));
      chk("tbl_err_once", 32'(err), 0);
      if (!vt[i].bad) begin
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("tbl_abort_idle", 32'(busy), 0);
      end
      cycle();
      chk("tbl_go_count", 32'(go_cnt - g0), 32'(!vt[i].bad));
      chk("tbl_err_count", 32'(err_cnt - e0), 32'(vt[i].bad));
    end

    // Abort together with start_req in IDLE rejects the start
    g0 = go_cnt;
    abort = 1'b1;
    start(3'd1, 3'd1);
    abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 0);
    cycle();
    chk("abort_start_go", 32'(go_cnt - g0), 0);

    // Full tour from (2,2) with mv_rdy high; a stray bad start_req while busy is ignored
    g0 = go_cnt; d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt;
    push_moves(NM);
    start(3'd2, 3'd2);
    repeat (5) cycle();
    start(3'd7, 3'd7);
    for (int k = 0; k < 2000; k++) begin
      if (tour_done) break;
      cycle();
    end
    chk("t1_done_seen", 32'(tour_done), 1);
    cycle();
    chk("t1_done_pulse", 32'(tour_done), 0);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    chk("t1_handshakes", 32'(hs_cnt - h0), NM);
    chk("t1_go_count", 32'(go_cnt - g0), 1);
    chk("t1_err_count", 32'(err_cnt - e0), 0);
    chk("t1_sb_empty", 32'(sb.size()), 0);
    chk("t1_throughput", 32'(hs_at[NM-1] - hs_at[0]), 32'(3 * (NM - 1)));
    chk("t1_slv_xy", 32'({slv_x, slv_y}), 32'({3'd2, 3'd2}));

    // Backpressure on move 7
    d0 = done_cnt;
    push_moves(NM);
    start(3'd1, 3'd3);
    for (int k = 0; k < 2000; k++) begin
      if (mv_vld && mv_idx == 5'd6) break;
      cycle();
    end
    cycle();
    mv_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mv_vld) break;
      cycle();
    end
    for (int k = 0; k < 10; k++) begin
      chk("stall_vld", 32'(mv_vld), 1);
      chk("stall_idx", 32'(mv_idx), 7);
      chk("stall_move", 32'(mv_move), 32'(mem[7]));
      chk("stall_slv_indx", 32'(slv_indx), 7);
      cycle();
    end
    mv_rdy = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (tour_done) break;
      cycle();
    end
    chk("stall_done_seen", 32'(tour_done), 1);
    cycle();
    chk("stall_done_count", 32'(done_cnt - d0), 1);
    chk("stall_sb_empty", 32'(sb.size()), 0);

    // Corrupt (two-hot) move at index 3
    mem[3] = 8'h06;
    d0 = done_cnt; e0 = err_cnt; h0 = hs_cnt;
    push_moves(3);
    start(3'd0, 3'd4);
    for (int k = 0; k < 2000; k++) begin
      if (err) break;
      cycle();
    end
    chk("badmv_err", 32'(err), 1);
    chk("badmv_code", 32'(err_code), 32'(2'b11));
    chk("badmv_captured", 32'({mv_move, mv_idx}), 32'({8'h06, 5'd3}));
    chk("badmv_vld", 32'(mv_vld), 0);
    cycle();
    chk("badmv_err_pulse", 32'(err), 0);
    chk("badmv_busy", 32'(busy), 0);
    chk("badmv_err_count", 32'(err_cnt - e0), 1);
    chk("badmv_no_done", 32'(done_cnt - d0), 0);
    chk("badmv_handshakes", 32'(hs_cnt - h0), 3);
    chk("badmv_sb_empty", 32'(sb.size()), 0);
    mem[3] = 8'h08;

    // Abort while issuing move 12, then a fresh tour restarts at index 0
    d0 = done_cnt; e0 = err_cnt;
    push_moves(12);
    start(3'd2, 3'd1);
    for (int k = 0; k < 2000; k++) begin
      if (mv_vld && mv_idx == 5'd11) break;
      cycle();
    end
    cycle();
    mv_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mv_vld) break;
      cycle();
    end
    chk("abort_at_idx", 32'(mv_idx), 12);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_vld", 32'(mv_vld), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_err", 32'(err), 0);
    cycle();
    chk("abort_err_count", 32'(err_cnt - e0), 0);
    chk("abort_done_count", 32'(done_cnt - d0), 0);
    chk("abort_sb_empty", 32'(sb.size()), 0);
    mv_rdy = 1'b1;
    push_moves(NM);
    start(3'd3, 3'd3);
    for (int k = 0; k < 2000; k++) begin
      if (mv_vld) break;
      cycle();
    end
    chk("restart_first_idx", 32'(mv_idx), 0);
    for (int k = 0; k < 2000; k++) begin
      if (tour_done) break;
      cycle();
    end
    chk("restart_done_seen", 32'(tour_done), 1);
    cycle();
    chk("restart_sb_empty", 32'(sb.size()), 0);

    // Synchronous reset with a move pending downstream
    mv_rdy = 1'b0;
    start(3'd1, 3'd2);
    for (int k = 0; k < 2000; k++) begin
      if (mv_vld) break;
      cycle();
    end
    chk("rst_mid_vld_before", 32'(mv_vld), 1);
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_outputs", all_outs(), 0);
    rst_n = 1'b1;
    mv_rdy = 1'b1;
    cycle();

`ifdef TOUR_TIMEOUT_EN
    // Solver never finishes: watchdog fires after 64 SOLVE cycles
    solve_dly = -1;
    start(3'd1, 3'd1);
    for (int k = 0; k < 10; k++) begin
      if (slv_go) break;
      cycle();
    end
    n = 0;
    for (int k = 0; k < 500; k++) begin
      if (err) break;
      cycle();
      n++;
    end
    chk("tmo_err", 32'(err), 1);
    chk("tmo_code", 32'(err_code), 32'(2'b10));
    chk("tmo_cycles", 32'(n), 64);
    cycle();
    start(3'd1, 3'd1);
    repeat (10) cycle();
    chk("tmo_solve_busy", 32'(busy), 1);
    rst_n = 1'b0;
    cycle();
    chk("tmo_rst_outputs", all_outs(), 0);
    rst_n = 1'b1;
    solve_dly = SOLVE_DLY;
    cycle();
`else
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
